pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives write-enables and flush/bubble controls for the PC, the IF/ID register, the ID/EX register and the EX/MEM register. It detects load-use and flag-use hazards and applies taken-branch flushes. A small FSM holds the whole pipeline during multi-cycle data-memory accesses. It also keeps saturating performance counters for stall and flush cycles.

Parameters:
REG_W, 5, register-address width
CNT_W, 16, width of each saturating performance counter

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
reset  in  1  asynchronous reset, active-low (0 = reset)
Rn_ID  in  REG_W  first source register of instruction in ID
Rm_ID  in  REG_W  second source register (Rd for stores/CBZ) in ID
usesRm_ID  in  1  ID instruction reads Rm_ID
usesFlags_ID  in  1  ID instruction is B.cond (reads flags)
memRead_EX  in  1  EX instruction is a load
targetReg_EX  in  REG_W  EX destination register
set_flags_EX  in  1  EX instruction writes flags at end of EX
br_taken_EX  in  1  branch in EX resolved taken this cycle
mem_busy  in  1  data memory not ready; MEM access must be held
pc_write  out  1  PC register load enable
ifid_write  out  1  IF/ID register load enable
ifid_flush  out  1  IF/ID loads a NOP instead of fetched instruction
idex_write  out  1  ID/EX register load enable
idex_bubble  out  1  ID/EX loads all-zero control bits (data fields don't-care)
exmem_write  out  1  EX/MEM and MEM/WB load enable
stall_cnt  out  CNT_W  cycles with pc_write=0 since reset
flush_cnt  out  CNT_W  number of taken-branch flushes since reset

Behaviour:
- Reset (reset=0, asynchronous): state=RUN, flush_pend=0, counters=0. Outputs: pc_write=0, ifid_write=0, idex_write=0, exmem_write=0, ifid_flush=1, idex_bubble=1. Outputs go to these values immediately, without waiting for a clock edge.
- FSM states: RUN, MEM_WAIT. Control outputs are combinational from the current state and inputs (zero-latency Mealy). State, flush_pend and counters are registered.
- Hazard terms:
  - X31 (XZR) never creates a hazard.
  - loaduse = memRead_EX & targetReg_EX!=31 & (Rn_ID==targetReg_EX | (usesRm_ID & Rm_ID==targetReg_EX)).
  - flaguse = usesFlags_ID & set_flags_EX.
- RUN priority, highest first:
  1. mem_busy: all write-enables 0, no flush/bubble. Next state MEM_WAIT. If br_taken_EX=1, set flush_pend.
  2. br_taken_EX | flush_pend: pc_write=1, ifid_write=1, ifid_flush=1, idex_write=1, idex_bubble=1, exmem_write=1. Clear flush_pend. flush_cnt increments.
  3. loaduse | flaguse: pc_write=0, ifid_write=0, idex_write=1, idex_bubble=1, exmem_write=1. Exactly one bubble per hazard; on the next cycle the producer has left EX, so the term clears.
  4. Otherwise: all write-enables 1, no flush/bubble.
- MEM_WAIT: all write-enables 0, no flush/bubble. br_taken_EX=1 sets flush_pend.
- MEM_WAIT exit: when mem_busy=0, next state is RUN. That same cycle is evaluated with the RUN rules, but with the mem_busy term masked out.
- A pending flush, or a branch still held in EX, takes effect on the first RUN cycle after the wait. It counts once only: flush_pend clears when the flush fires.
- stall_cnt increments on every cycle where pc_write=0 and reset=1. flush_cnt increments on every fired flush.
- Both counters saturate at all-ones and never wrap.
- Simultaneous branch taken and load-use: the branch wins. The ID instruction is flushed, so no stall is issued.
- Reset deasserted mid-wait: the FSM returns to RUN and flush_pend is lost. This is intended.

Test Plan:
- Reset: hold reset=0 with random inputs → pc_write=0, ifid_flush=1, idex_bubble=1, counters 0. Release, no hazards → all enables 1 on the next cycle.
- Load-use: memRead_EX=1, targetReg_EX=5, Rn_ID=5 → exactly one cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt=1. Same stimulus with targetReg_EX=31 → no stall.
- Flag use: usesFlags_ID=1, set_flags_EX=1 → one bubble. Same with set_flags_EX=0 → none.
- Branch flush: br_taken_EX=1 together with loaduse=1 → ifid_flush=1, idex_bubble=1, pc_write=1; flush_cnt=1; stall_cnt unchanged.
- Memory wait: mem_busy=1 for 3 cycles with br_taken_EX pulsed in cycle 1 → 3 cycles of all enables 0, then exactly one flush cycle; stall_cnt=3, flush_cnt=1.
- Saturation: force 2^CNT_W+5 stall cycles → stall_cnt stays 0xFFFF. Then assert reset=0 between clock edges → counters clear immediately.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Purpose : stall/flush sequencer for a 5-stage pipeline (PC, IF/ID, ID/EX, EX/MEM enables).
// Latency : control outputs are combinational from state + inputs; counters update on the clock edge.
// Backpr. : mem_busy freezes every pipeline register; a branch seen during the freeze is replayed after it.
//
// Ports:
//   clk, reset (async, active-low)
//   Rn_ID/Rm_ID/usesRm_ID/usesFlags_ID : consumer in ID
//   memRead_EX/targetReg_EX/set_flags_EX/br_taken_EX : producer / branch in EX
//   mem_busy : data memory not ready
//   pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write : pipeline controls
//   stall_cnt, flush_cnt : saturating performance counters
module pipeline_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rn_ID,
  input  logic [REG_W-1:0] Rm_ID,
  input  logic             usesRm_ID,
  input  logic             usesFlags_ID,
  input  logic             memRead_EX,
  input  logic [REG_W-1:0] targetReg_EX,
  input  logic             set_flags_EX,
  input  logic             br_taken_EX,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Zero register: reads as zero, writes discarded, so it never forms a dependency.
  localparam logic [REG_W-1:0] XZR = '1;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t           state_q, state_d;
  logic             flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             loaduse, flaguse, flush_fire;

  assign loaduse = memRead_EX && (targetReg_EX != XZR) &&
                   ((Rn_ID == targetReg_EX) || (usesRm_ID && (Rm_ID == targetReg_EX)));
  assign flaguse = usesFlags_ID && set_flags_EX;

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b1;
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    flush_fire   = 1'b0;

    // In MEM_WAIT the exit cycle follows the RUN rules with mem_busy already
    // low, so both states share one evaluation keyed on mem_busy.
    if (mem_busy) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      state_d     = MEM_WAIT;
      // The branch may leave EX before the freeze lifts; remember it.
      if (br_taken_EX) flush_pend_d = 1'b1;
    end else begin
      state_d = RUN;
      if (br_taken_EX || flush_pend_q) begin
        // Branch beats load-use: the dependent instruction is discarded anyway.
        ifid_flush   = 1'b1;
        idex_bubble  = 1'b1;
        flush_pend_d = 1'b0;
        flush_fire   = 1'b1;
      end else if (loaduse || flaguse) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end

    // Reset forces safe controls immediately, independent of the clock.
    if (!reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_write  = 1'b0;
      idex_bubble = 1'b1;
      exmem_write = 1'b0;
      flush_fire  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      flush_pend_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (flush_fire && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  // Expected control patterns {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write}
  localparam logic [5:0] C_NORM  = 6'b110101;
  localparam logic [5:0] C_STALL = 6'b000111;
  localparam logic [5:0] C_FLUSH = 6'b111111;
  localparam logic [5:0] C_HOLD  = 6'b000000;
  localparam logic [5:0] C_RST   = 6'b001010;

  logic             clk;
  logic             reset;
  logic [REG_W-1:0] Rn_ID, Rm_ID, targetReg_EX;
  logic             usesRm_ID, usesFlags_ID, memRead_EX, set_flags_EX, br_taken_EX, mem_busy;
  logic             pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic        urm;
    logic        ufl;
    logic        mrd;
    logic [4:0]  tgt;
    logic        sfl;
    logic        br;
    logic        busy;
    logic [5:0]  ctl;
    logic [15:0] st;
    logic [15:0] fl;
  } vec_t;

  vec_t vecs[21];

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .Rn_ID        (Rn_ID),
    .Rm_ID        (Rm_ID),
    .usesRm_ID    (usesRm_ID),
    .usesFlags_ID (usesFlags_ID),
    .memRead_EX   (memRead_EX),
    .targetReg_EX (targetReg_EX),
    .set_flags_EX (set_flags_EX),
    .br_taken_EX  (br_taken_EX),
    .mem_busy     (mem_busy),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_write   (idex_write),
    .idex_bubble  (idex_bubble),
    .exmem_write  (exmem_write),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] ctl_now();
    return {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    Rn_ID        = v.rn;
    Rm_ID        = v.rm;
    usesRm_ID    = v.urm;
    usesFlags_ID = v.ufl;
    memRead_EX   = v.mrd;
    targetReg_EX = v.tgt;
    set_flags_EX = v.sfl;
    br_taken_EX  = v.br;
    mem_busy     = v.busy;
  endtask

  // Called at a falling edge: drive, check controls, clock, check counters, return at next falling edge.
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    #1;
    chk({tag, ".ctl"}, {26'd0, ctl_now()}, {26'd0, v.ctl});
    @(posedge clk);
    #1;
    chk({tag, ".stall_cnt"}, {16'd0, stall_cnt}, {16'd0, v.st});
    chk({tag, ".flush_cnt"}, {16'd0, flush_cnt}, {16'd0, v.fl});
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic [4:0] rn, input logic [4:0] rm, input logic urm,
                              input logic ufl, input logic mrd, input logic [4:0] tgt,
                              input logic sfl, input logic br, input logic busy,
                              input logic [5:0] ctl, input logic [15:0] st, input logic [15:0] fl);
    vec_t v;
    v.rn = rn; v.rm = rm; v.urm = urm; v.ufl = ufl; v.mrd = mrd; v.tgt = tgt;
    v.sfl = sfl; v.br = br; v.busy = busy; v.ctl = ctl; v.st = st; v.fl = fl;
    return v;
  endfunction

  initial begin
    vec_t idle;
    //            rn  rm urm ufl mrd tgt sfl br busy  ctl     st fl
    vecs[0]  = mk( 1,  2, 0, 0, 0,  3, 0, 0, 0, C_NORM,  0, 0); // first cycle after reset
    vecs[1]  = mk( 5,  2, 0, 0, 1,  5, 0, 0, 0, C_STALL, 1, 0); // load-use on Rn
    vecs[2]  = mk( 5,  2, 0, 0, 0,  5, 0, 0, 0, C_NORM,  1, 0); // producer left EX
    vecs[3]  = mk(31,  2, 0, 0, 1, 31, 0, 0, 0, C_NORM,  1, 0); // XZR load: no hazard
    vecs[4]  = mk( 1,  7, 1, 0, 1,  7, 0, 0, 0, C_STALL, 2, 0); // load-use on Rm
    vecs[5]  = mk( 1,  7, 0, 0, 1,  7, 0, 0, 0, C_NORM,  2, 0); // Rm match but not read
    vecs[6]  = mk( 1,  2, 0, 1, 0,  3, 1, 0, 0, C_STALL, 3, 0); // flag-use
    vecs[7]  = mk( 1,  2, 0, 1, 0,  3, 0, 0, 0, C_NORM,  3, 0); // B.cond, no flag writer
    vecs[8]  = mk( 5,  2, 0, 0, 1,  5, 0, 1, 0, C_FLUSH, 3, 1); // branch beats load-use
    vecs[9]  = mk( 1,  2, 0, 0, 0,  3, 0, 0, 0, C_NORM,  3, 1);
    vecs[10] = mk( 1,  2, 0, 0, 0,  3, 0, 1, 1, C_HOLD,  4, 1); // mem wait 1, branch pulse
    vecs[11] = mk( 1,  2, 0, 0, 0,  3, 0, 0, 1, C_HOLD,  5, 1); // mem wait 2
    vecs[12] = mk( 1,  2, 0, 0, 0,  3, 0, 0, 1, C_HOLD,  6, 1); // mem wait 3
    vecs[13] = mk( 1,  2, 0, 0, 0,  3, 0, 0, 0, C_FLUSH, 6, 2); // pending flush fires
    vecs[14] = mk( 1,  2, 0, 0, 0,  3, 0, 0, 0, C_NORM,  6, 2); // ... only once
    vecs[15] = mk( 1,  2, 0, 0, 0,  3, 0, 0, 1, C_HOLD,  7, 2);
    vecs[16] = mk( 5,  2, 0, 0, 1,  5, 0, 0, 0, C_STALL, 8, 2); // wait exit into load-use
    vecs[17] = mk( 1,  2, 0, 1, 0,  3, 1, 0, 1, C_HOLD,  9, 2); // mem_busy beats flag-use
    vecs[18] = mk( 1,  2, 0, 0, 0,  3, 0, 1, 0, C_FLUSH, 9, 3); // branch held in EX after wait
    vecs[19] = mk( 1,  2, 0, 0, 0,  3, 0, 0, 0, C_NORM,  9, 3);
    vecs[20] = mk( 1, 31, 1, 0, 1, 31, 0, 0, 0, C_NORM,  9, 3); // XZR on Rm
    idle = vecs[0];

    // Reset held with random inputs: safe controls and cleared counters.
    reset = 1'b0;
    drive(idle);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      Rn_ID = 5'($urandom); Rm_ID = 5'($urandom); targetReg_EX = 5'($urandom);
      {usesRm_ID, usesFlags_ID, memRead_EX, set_flags_EX, br_taken_EX, mem_busy} = 6'($urandom);
      #1;
      chk("rst.ctl", {26'd0, ctl_now()}, {26'd0, C_RST});
      chk("rst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
      chk("rst.flush_cnt", {16'd0, flush_cnt}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 21; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // A pending flush is discarded by reset mid-wait.
    apply(mk(1, 2, 0, 0, 0, 3, 0, 1, 1, C_HOLD, 10, 3), "pend.busy");
    drive(idle);
    reset = 1'b0;
    #1;
    chk("pend.rst.ctl", {26'd0, ctl_now()}, {26'd0, C_RST});
    chk("pend.rst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    apply(mk(1, 2, 0, 0, 0, 3, 0, 0, 0, C_NORM, 0, 0), "pend.lost");

    // Saturation: 2^16+5 stall cycles.
    drive(mk(1, 2, 0, 0, 0, 3, 0, 0, 1, C_HOLD, 0, 0));
    repeat (65541) @(posedge clk);
    @(negedge clk);
    chk("sat.stall_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
    chk("sat.flush_cnt", {16'd0, flush_cnt}, 32'd0);

    // Reset between edges clears counters without a clock.
    #2;
    reset = 1'b0;
    #1;
    chk("async.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("async.ctl", {26'd0, ctl_now()}, {26'd0, C_RST});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
